ritc_vcdl_phase_scanner: RTL and testbench

Calibration engine that sits directly downstream of the RITC VCDL generator. It sweeps the generator's 5-bit VCDL sync IDELAY tap from 0 to 31 and, at each tap, counts how often the delayed VCDL sync loopback is high on a reference strobe. It stores a per-tap histogram, locates the first 0→1 transition, and loads that tap back into the delay. Software reads the result and the histogram over a simple read port.

---
 rtl/ritc_vcdl_phase_scanner.sv | 147 ++++++++++++++
 tb/tb_ritc_vcdl_phase_scanner.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ritc_vcdl_phase_scanner.sv
// Purpose: sweeps the VCDL sync IDELAY tap from 0 to 31 and builds a per-tap histogram of strobed highs.
//          It then locates the first 0->1 tap transition and reloads that tap into the delay.
// Latency: the scan takes 32 x (1 + SETTLE_CYCLES + 2^SAMPLE_LOG2 + 1) + 2 cycles at minimum; histogram reads take 1 cycle.
// Backpressure: SETTLE waits while idelayctrl_rdy_i is low, ACCUM waits for sample strobes, and start_i is ignored while busy.
// Ports: CLK/rst_i clock and async reset; start_i scan request; idelayctrl_rdy_i, sample_strobe_i and vcdl_sync_i
//        come from the generator side; delay_o/load_delay_o drive the generator; busy_o/done_o/edge_found_o/edge_tap_o
//        report status; rd_addr_i/rd_data_o form the histogram read port.
module ritc_vcdl_phase_scanner #(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_LOG2   = 8
) (
  input  logic                 CLK,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 idelayctrl_rdy_i,
  input  logic                 sample_strobe_i,
  input  logic                 vcdl_sync_i,
  output logic [4:0]           delay_o,
  output logic                 load_delay_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 edge_found_o,
  output logic [4:0]           edge_tap_o,
  input  logic [4:0]           rd_addr_i,
  output logic [SAMPLE_LOG2:0] rd_data_o
);

  localparam int CW = SAMPLE_LOG2 + 1;
  localparam logic [CW-1:0] SAMPLE_LAST = CW'((1 << SAMPLE_LOG2) - 1);
  localparam logic [CW-1:0] HALF        = CW'(1 << (SAMPLE_LOG2 - 1));
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_ACCUM  = 3'd3;
  localparam logic [2:0] S_EVAL   = 3'd4;
  localparam logic [2:0] S_FINAL  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]    state;
  logic [4:0]    tap;
  logic [7:0]    settle_cnt;
  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] ones;
  logic          prev_bit;
  logic          edge_found;
  logic [4:0]    edge_tap;
  logic [4:0]    delay_q;
  logic [CW-1:0] hist [32];
  logic [CW-1:0] rd_data;

  logic          sample_bit;
  logic          edge_hit;

  // A strict majority is required, so exactly half of the samples counts as low.
  assign sample_bit = (ones > HALF);
  // Tap 0 has no predecessor, so it can never be an edge. Only the first edge is kept.
  assign edge_hit   = (tap != 5'd0) && !prev_bit && sample_bit && !edge_found;

  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      tap        <= 5'd0;
      settle_cnt <= 8'd0;
      sample_cnt <= '0;
      ones       <= '0;
      prev_bit   <= 1'b0;
      edge_found <= 1'b0;
      edge_tap   <= 5'd0;
      delay_q    <= 5'd0;
      rd_data    <= '0;
      for (int i = 0; i < 32; i++) begin
        hist[i] <= '0;
      end
    end else begin
      rd_data <= hist[rd_addr_i];
      case (state)
        S_IDLE: begin
          // Results are held after a scan and cleared only when a new scan is accepted.
          if (start_i) begin
            tap        <= 5'd0;
            prev_bit   <= 1'b0;
            edge_found <= 1'b0;
            edge_tap   <= 5'd0;
            delay_q    <= 5'd0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          settle_cnt <= 8'd0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          // The count freezes, rather than restarting, while the IDELAYCTRL is not ready.
          if (idelayctrl_rdy_i) begin
            if (settle_cnt == SETTLE_LAST) begin
              sample_cnt <= '0;
              ones       <= '0;
              state      <= S_ACCUM;
            end else begin
              settle_cnt <= settle_cnt + 8'd1;
            end
          end
        end
        S_ACCUM: begin
          if (sample_strobe_i) begin
            sample_cnt <= sample_cnt + CW'(1);
            ones       <= ones + CW'(vcdl_sync_i);
            if (sample_cnt == SAMPLE_LAST) begin
              state <= S_EVAL;
            end
          end
        end
        S_EVAL: begin
          hist[tap] <= ones;
          prev_bit  <= sample_bit;
          if (edge_hit) begin
            edge_found <= 1'b1;
            edge_tap   <= tap;
          end
          // delay_q is set up here so that it is valid during the next load pulse.
          if (tap == 5'd31) begin
            delay_q <= edge_hit ? tap : edge_tap;
            state   <= S_FINAL;
          end else begin
            tap     <= tap + 5'd1;
            delay_q <= tap + 5'd1;
            state   <= S_LOAD;
          end
        end
        S_FINAL: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign delay_o      = delay_q;
  assign load_delay_o = (state == S_LOAD) || (state == S_FINAL);
  assign busy_o       = (state != S_IDLE);
  assign done_o       = (state == S_DONE);
  assign edge_found_o = edge_found;
  assign edge_tap_o   = edge_tap;
  assign rd_data_o    = rd_data;

endmodule

// File: tb/tb_ritc_vcdl_phase_scanner.sv
// Purpose: directed bench for the VCDL phase scanner. A high-level per-tap model predicts the histogram, the edge and the load sequence.
// Latency: scans are checked against the closed-form scan length, and histogram reads are checked one cycle after the address is set.
// Backpressure: exercises idelayctrl_rdy_i stalls, sparse strobes and start_i while busy.
module tb_ritc_vcdl_phase_scanner;

  localparam int SETTLE   = 16;
  localparam int SL       = 8;
  localparam int NS       = 1 << SL;
  localparam int TAP_LEN  = 1 + SETTLE + NS + 1;
  localparam int SCAN_LEN = 32 * TAP_LEN + 2;

  logic          CLK = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          idelayctrl_rdy_i;
  logic          sample_strobe_i;
  logic          vcdl_sync_i;
  logic [4:0]    delay_o;
  logic          load_delay_o;
  logic          busy_o;
  logic          done_o;
  logic          edge_found_o;
  logic [4:0]    edge_tap_o;
  logic [4:0]    rd_addr_i;
  logic [SL:0]   rd_data_o;

  ritc_vcdl_phase_scanner #(.SETTLE_CYCLES(SETTLE), .SAMPLE_LOG2(SL)) dut (
    .CLK              (CLK),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .idelayctrl_rdy_i (idelayctrl_rdy_i),
    .sample_strobe_i  (sample_strobe_i),
    .vcdl_sync_i      (vcdl_sync_i),
    .delay_o          (delay_o),
    .load_delay_o     (load_delay_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .edge_found_o     (edge_found_o),
    .edge_tap_o       (edge_tap_o),
    .rd_addr_i        (rd_addr_i),
    .rd_data_o        (rd_data_o)
  );

  initial forever #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Per-tap number of ones that the stimulus presents during ACCUM.
  int pat [32];
  int exp_hist [32];
  bit exp_found;
  int exp_edge;
  int exp_q [$];
  bit strobe4 = 1'b0;
  int cur_tap = 0;
  int load_cyc = -100000;
  bit done_seen;
  int done_cyc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_pat(input int kind);
    for (int t = 0; t < 32; t++) begin
      case (kind)
        0: pat[t] = 0;
        1: pat[t] = (t >= 12) ? NS : 0;
        2: pat[t] = (t < 5) ? 0 : (t == 5) ? NS / 2 : NS;
        3: pat[t] = (t < 5) ? 0 : (t == 5) ? NS / 2 + 1 : NS;
        default: pat[t] = (t == 0 || t == 3 || t == 4 || t >= 10) ? NS : 0;
      endcase
    end
  endtask

  // Model: each tap's bit is a strict majority. The edge is the first low-to-high pair
  // across adjacent taps. The loads are taps 0..31 followed by the edge tap.
  task automatic calc_model();
    bit b [32];
    exp_found = 1'b0;
    exp_edge  = 0;
    for (int t = 0; t < 32; t++) begin
      exp_hist[t] = pat[t];
      b[t] = (pat[t] > NS / 2);
    end
    for (int t = 1; t < 32; t++) begin
      if (!exp_found && !b[t-1] && b[t]) begin
        exp_found = 1'b1;
        exp_edge  = t;
      end
    end
    exp_q.delete();
    for (int t = 0; t < 32; t++) exp_q.push_back(t);
    exp_q.push_back(exp_edge);
  endtask

  // Stimulus for the generator side. ACCUM starts SETTLE+1 cycles after the load pulse while rdy stays high.
  // k is the index of the ACCUM cycle, and the first pat[tap] strobed samples are high.
  initial begin
    int k;
    vcdl_sync_i     = 1'b0;
    sample_strobe_i = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (load_delay_o === 1'b1) begin
        cur_tap  = int'(delay_o);
        load_cyc = cyc;
      end
      k = cyc - load_cyc - 1 - SETTLE;
      sample_strobe_i = strobe4 ? (k >= 0 && (k % 4) == 3) : 1'b1;
      vcdl_sync_i     = (pat[cur_tap] >= NS) || (k >= 0 && k < pat[cur_tap]);
    end
  end

  // Compare process: every load pulse must carry the next tap the model expects, and done must report the model's edge.
  initial begin
    int e;
    forever begin
      @(negedge CLK);
      if (!rst_i && load_delay_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_load", int'(load_delay_o), 0);
        end else begin
          e = exp_q.pop_front();
          chk("load_delay_tap", int'(delay_o), e);
          chk("busy_on_load", int'(busy_o), 1);
        end
      end
      if (!rst_i && done_o === 1'b1) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        chk("done_edge_found", int'(edge_found_o), int'(exp_found));
        chk("done_edge_tap", int'(edge_tap_o), exp_edge);
      end
    end
  end

  task automatic read_hist();
    for (int a = 0; a < 32; a++) begin
      @(posedge CLK); #1 rd_addr_i = 5'(a);
      @(posedge CLK); #1;
      chk($sformatf("hist[%0d]", a), int'(rd_data_o), exp_hist[a]);
    end
  endtask

  task automatic run_scan(input int exp_len, input bit stall, input bit poke,
                          input int lit_found, input int lit_edge);
    int t0;
    int i;
    calc_model();
    done_seen = 1'b0;
    @(posedge CLK); #1 start_i = 1'b1;
    t0 = cyc;
    i = 0;
    while (i < exp_len + 4) begin
      @(posedge CLK); #1;
      i = cyc - t0;
      start_i = poke && (i == 100 || i == exp_len);
      idelayctrl_rdy_i = !(stall && i >= 6 && i < 56);
      if (i == 1) chk("busy_rise", int'(busy_o), 1);
      if (i == exp_len + 1) chk("busy_fall", int'(busy_o), 0);
    end
    start_i = 1'b0;
    chk("done_seen", int'(done_seen), 1);
    if (done_seen) chk("done_latency", done_cyc - t0, exp_len);
    chk("loads_outstanding", exp_q.size(), 0);
    chk("idle_after_scan", int'(busy_o), 0);
    chk("edge_found_lit", int'(edge_found_o), lit_found);
    chk("edge_tap_lit", int'(edge_tap_o), lit_edge);
    read_hist();
  endtask

  initial begin
    int n;
    int l1;
    int l2;
    bit got20;
    rst_i = 1'b1;
    start_i = 1'b0;
    idelayctrl_rdy_i = 1'b1;
    rd_addr_i = 5'd0;
    set_pat(0);
    calc_model();
    exp_q.delete();
    repeat (3) @(negedge CLK);
    chk("rst_delay", int'(delay_o), 0);
    chk("rst_load", int'(load_delay_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_edge_found", int'(edge_found_o), 0);
    chk("rst_rd_data", int'(rd_data_o), 0);
    @(posedge CLK); #1 rst_i = 1'b0;
    repeat (4) @(posedge CLK);
    #1 chk("idle_no_start", int'(busy_o), 0);

    // All-zero input, with start_i pulsed mid-scan and again on the done cycle.
    set_pat(0); run_scan(SCAN_LEN, 1'b0, 1'b1, 0, 0);
    // Step at tap 12, with a 50-cycle rdy drop during the tap 0 settle.
    set_pat(1); run_scan(SCAN_LEN + 50, 1'b1, 1'b0, 1, 12);
    // Exactly half at tap 5 is low. One more sample than half is high.
    set_pat(2); run_scan(SCAN_LEN, 1'b0, 1'b0, 1, 6);
    set_pat(3); run_scan(SCAN_LEN, 1'b0, 1'b0, 1, 5);
    // Tap 0 is high, then taps 3-4, then taps 10-31. Only the first edge is kept.
    set_pat(4); run_scan(SCAN_LEN, 1'b0, 1'b0, 1, 3);

    // Sparse strobes on tap 0, then async reset mid-ACCUM at tap 20.
    set_pat(1); calc_model();
    strobe4 = 1'b1;
    rd_addr_i = 5'd12;
    n = 0; l1 = 0; l2 = 0; got20 = 1'b0;
    @(posedge CLK); #1 start_i = 1'b1;
    for (int c = 0; c < 30000 && !got20; c++) begin
      @(posedge CLK); #1;
      start_i = 1'b0;
      if (load_delay_o === 1'b1) begin
        n++;
        if (n == 1) l1 = cyc;
        if (n == 2) begin l2 = cyc; strobe4 = 1'b0; end
        if (delay_o == 5'd20) got20 = 1'b1;
      end
    end
    strobe4 = 1'b0;
    chk("strobe4_tap_period", l2 - l1, 1 + SETTLE + 4 * NS + 1);
    chk("reached_tap20", int'(got20), 1);
    repeat (SETTLE + 50) @(posedge CLK);
    #1;
    chk("busy_before_rst", int'(busy_o), 1);
    chk("rd_before_rst", int'(rd_data_o), NS);
    chk("edge_before_rst", int'(edge_tap_o), 12);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_delay", int'(delay_o), 0);
    chk("arst_load", int'(load_delay_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_edge_found", int'(edge_found_o), 0);
    chk("arst_edge_tap", int'(edge_tap_o), 0);
    chk("arst_rd_data", int'(rd_data_o), 0);
    exp_q.delete();
    repeat (3) @(posedge CLK);
    #1 rst_i = 1'b0;
    repeat (5) @(posedge CLK);
    #1 chk("no_load_on_reset_exit", int'(busy_o), 0);
    set_pat(0); calc_model(); exp_q.delete();
    read_hist();

    // A clean rescan after the reset.
    set_pat(1); run_scan(SCAN_LEN, 1'b0, 1'b0, 1, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
